// File: rtl/function_arbiter_pkg.sv
// Shared encodings for the two-user vehicle-function arbiter.
`timescale 1ns/1ps
package function_arbiter_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_OPEN, ST_SWITCH} arb_state_t;

    localparam int FUNC_NONE = 0;
    localparam int PROF_W    = 2;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_U1   = 2'b01;
    localparam logic [1:0] GNT_U2   = 2'b10;
endpackage

// File: rtl/function_arbiter_arb_pick.sv
// Combinational winner selection: higher profile wins, ties go to the user the rr pointer favours.
`timescale 1ns/1ps
module arb_pick
    import function_arbiter_pkg::*;
(
    input  logic [1:0]        effreq,
    input  logic [PROF_W-1:0] prof1,
    input  logic [PROF_W-1:0] prof2,
    input  logic              rr,
    output logic [1:0]        win
);
    always_comb begin
        win = GNT_NONE;
        case (effreq)
            2'b01: win = GNT_U1;
            2'b10: win = GNT_U2;
            2'b11: begin
                if (prof1 > prof2)      win = GNT_U1;
                else if (prof2 > prof1) win = GNT_U2;
                else                    win = rr ? GNT_U2 : GNT_U1;
            end
            default: win = GNT_NONE;
        endcase
    end
endmodule

// File: rtl/function_arbiter.sv
// Timed ownership arbiter: minimum hold, profile preemption, fair rotation, dead cycle per owner change.
`timescale 1ns/1ps
module function_arbiter
    import function_arbiter_pkg::*;
#(
    parameter int MIN_HOLD  = 8,
    parameter int MAX_GRANT = 64,
    parameter int FW        = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [PROF_W-1:0] prof1,
    input  logic [PROF_W-1:0] prof2,
    input  logic [FW-1:0]     func1,
    input  logic [FW-1:0]     func2,
    output logic [1:0]        gnt,
    output logic [FW-1:0]     active_f,
    output logic [PROF_W-1:0] active_u,
    output logic              busy,
    output logic              preempt
);
    localparam int CW = $clog2(MAX_GRANT);
    localparam logic [CW-1:0] CNT_HOLD_END = CW'(MIN_HOLD - 1);
    localparam logic [CW-1:0] CNT_MAX      = CW'(MAX_GRANT - 1);

    arb_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic              rr_q, rr_d;
    logic [1:0]        gnt_d, effreq, win;
    logic [FW-1:0]     active_f_d;
    logic [PROF_W-1:0] active_u_d, other_prof;
    logic              preempt_d, owner_req, other_req, drop, grant_now;

    assign effreq[0]  = req[0] & (func1 != FW'(FUNC_NONE));
    assign effreq[1]  = req[1] & (func2 != FW'(FUNC_NONE));
    // gnt is the owner one-hot while holding, so its complement selects the waiter
    assign owner_req  = |(effreq & gnt);
    assign other_req  = |(effreq & ~gnt);
    assign other_prof = gnt[0] ? prof2 : prof1;
    assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    arb_pick u_pick (
        .effreq (effreq),
        .prof1  (prof1),
        .prof2  (prof2),
        .rr     (rr_q),
        .win    (win)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        gnt_d      = gnt;
        active_f_d = active_f;
        active_u_d = active_u;
        preempt_d  = 1'b0;
        drop       = 1'b0;
        grant_now  = 1'b0;
        case (state_q)
            ST_IDLE, ST_SWITCH: begin
                state_d    = ST_IDLE;
                gnt_d      = GNT_NONE;
                active_f_d = '0;
                active_u_d = '0;
                grant_now  = |win;
            end
            ST_HOLD: begin
                if (!owner_req) drop = 1'b1;
                else begin
                    if (cnt_q == CNT_HOLD_END) state_d = ST_OPEN;
                    cnt_d = cnt_inc;
                end
            end
            ST_OPEN: begin
                if (!owner_req) drop = 1'b1;
                else if (other_req && (other_prof > active_u)) begin
                    drop      = 1'b1;
                    preempt_d = 1'b1;
                end else if (other_req && (other_prof == active_u) && (cnt_q == CNT_MAX))
                    drop = 1'b1;
                else cnt_d = cnt_inc;
            end
            default: state_d = ST_IDLE;
        endcase
        if (drop) begin
            state_d    = ST_SWITCH;
            gnt_d      = GNT_NONE;
            active_f_d = '0;
            active_u_d = '0;
        end
        if (grant_now) begin
            state_d    = ST_HOLD;
            cnt_d      = '0;
            gnt_d      = win;
            active_f_d = win[0] ? func1 : func2;
            active_u_d = win[0] ? prof1 : prof2;
            rr_d       = win[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rr_q     <= 1'b0;
            gnt      <= GNT_NONE;
            active_f <= '0;
            active_u <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            gnt      <= gnt_d;
            active_f <= active_f_d;
            active_u <= active_u_d;
            busy     <= |gnt_d;
            preempt  <= preempt_d;
        end
    end
endmodule
